// File: rtl/hashtable_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hashtable_pkg
// Purpose  : Shared op encoding, clear-FSM states, forward-select codes and
//            bitmap RAM read latency for hashtable_updater.
// Revision : 1.0 - initial release
// ============================================================================
package hashtable_pkg;

  localparam int RD_LAT = 2;

  localparam logic HTU_OP_CLR = 1'b0;
  localparam logic HTU_OP_SET = 1'b1;

  // Forward source, named by the stage the older op occupied at issue time
  localparam logic [1:0] HTU_FWD_NONE = 2'd0;
  localparam logic [1:0] HTU_FWD_S1   = 2'd1;
  localparam logic [1:0] HTU_FWD_S2   = 2'd2;
  localparam logic [1:0] HTU_FWD_S3   = 2'd3;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_DRAIN = 2'd1,
    CLR_SWEEP = 2'd2
  } clr_state_t;

endpackage
`default_nettype wire

// File: rtl/htu_hazard.sv
`default_nettype none
// ============================================================================
// Module   : htu_hazard
// Purpose  : Matches an incoming byte address against the three in-flight
//            stages; returns a stall flag, or with HTU_FWD_EN a forward select.
// Revision : 1.0 - initial release
// ============================================================================
module htu_hazard
  import hashtable_pkg::*;
#(
  parameter int AWIDTH = 12
) (
  input  logic [AWIDTH-1:0] i_byte,
  input  logic              i_s1_valid,
  input  logic [AWIDTH-1:0] i_s1_byte,
  input  logic              i_s2_valid,
  input  logic [AWIDTH-1:0] i_s2_byte,
  input  logic              i_s3_valid,
  input  logic [AWIDTH-1:0] i_s3_byte,
  output logic              o_stall,
  output logic [1:0]        o_fwd_sel
);

  logic w_hit1;
  logic w_hit2;
  logic w_hit3;

  assign w_hit1 = i_s1_valid && (i_s1_byte == i_byte);
  assign w_hit2 = i_s2_valid && (i_s2_byte == i_byte);
  assign w_hit3 = i_s3_valid && (i_s3_byte == i_byte);

`ifdef HTU_FWD_EN
  // Youngest matching op wins, since it already folded in any older ones
  always_comb begin
    o_fwd_sel = HTU_FWD_NONE;
    if (w_hit3) o_fwd_sel = HTU_FWD_S3;
    if (w_hit2) o_fwd_sel = HTU_FWD_S2;
    if (w_hit1) o_fwd_sel = HTU_FWD_S1;
  end
  assign o_stall = 1'b0;
`else
  assign o_fwd_sel = HTU_FWD_NONE;
  assign o_stall   = w_hit1 | w_hit2 | w_hit3;
`endif

endmodule
`default_nettype wire

// File: rtl/hashtable_updater.sv
`default_nettype none
// ============================================================================
// Module   : hashtable_updater
// Purpose  : Read-modify-write bitmap updater with whole-bitmap clear sweep.
//            Macro HTU_FWD_EN selects forwarding instead of hazard stalls.
// Revision : 1.0 - initial release
// ============================================================================
module hashtable_updater
  import hashtable_pkg::*;
#(
  parameter int NBITS     = 15,
  parameter int BM_AWIDTH = NBITS - 3,
  parameter int RD_LAT    = hashtable_pkg::RD_LAT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NBITS-1:0]     in_addr,
  input  logic                 in_op,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 clr_all_req,
  output logic                 clr_all_busy,
  output logic                 mem_rd_en,
  output logic [BM_AWIDTH-1:0] mem_rd_addr,
  input  logic [7:0]           mem_rdata,
  output logic                 mem_wr_en,
  output logic [BM_AWIDTH-1:0] mem_wr_addr,
  output logic [7:0]           mem_wdata,
  output logic [31:0]          upd_cnt
);

  localparam logic [BM_AWIDTH-1:0] c_SWEEP_LAST = '1;

  clr_state_t r_state;
  clr_state_t w_state_nxt;
  logic [BM_AWIDTH-1:0] r_sweep_addr;
  logic [BM_AWIDTH-1:0] w_sweep_nxt;
  logic                 r_alive;

  // Read-latency pipeline: index 0 is T+1, index RD_LAT-1 is the modify stage
  logic [RD_LAT-1:0]                r_pv;
  logic [RD_LAT-1:0][BM_AWIDTH-1:0] r_pa;
  logic [RD_LAT-1:0][2:0]           r_pb;
  logic [RD_LAT-1:0]                r_pop;
  logic [RD_LAT-1:0][1:0]           r_psel;

  logic                 r_wr_v;
  logic [BM_AWIDTH-1:0] r_wr_addr;
  logic [7:0]           r_wr_data;
  logic [7:0]           r_h1_data;
  logic [7:0]           r_h2_data;
  logic [31:0]          r_upd_cnt;

  logic [BM_AWIDTH-1:0] w_byte;
  logic                 w_stall;
  logic [1:0]           w_fwd_sel;
  logic                 w_accept;
  logic                 w_sweeping;
  logic [7:0]           w_base;
  logic [7:0]           w_mod;

  assign w_byte = in_addr[NBITS-1:3];

  htu_hazard #(
    .AWIDTH (BM_AWIDTH)
  ) u_hazard (
    .i_byte     (w_byte),
    .i_s1_valid (r_pv[0]),
    .i_s1_byte  (r_pa[0]),
    .i_s2_valid (r_pv[RD_LAT-1]),
    .i_s2_byte  (r_pa[RD_LAT-1]),
    .i_s3_valid (r_wr_v),
    .i_s3_byte  (r_wr_addr),
    .o_stall    (w_stall),
    .o_fwd_sel  (w_fwd_sel)
  );

  assign in_ready     = r_alive && (r_state == CLR_IDLE) && !w_stall;
  assign w_accept     = in_valid && in_ready;
  assign mem_rd_en    = w_accept;
  assign mem_rd_addr  = w_accept ? w_byte : '0;
  assign clr_all_busy = (r_state != CLR_IDLE);
  assign w_sweeping   = (r_state == CLR_SWEEP);
  assign mem_wr_en    = r_wr_v || w_sweeping;
  assign mem_wr_addr  = w_sweeping ? r_sweep_addr : r_wr_addr;
  assign mem_wdata    = w_sweeping ? 8'h00 : r_wr_data;
  assign upd_cnt      = r_upd_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep_addr;
    case (r_state)
      CLR_IDLE: begin
        if (clr_all_req) w_state_nxt = CLR_DRAIN;
      end
      CLR_DRAIN: begin
        // A write still in its output register retires this cycle
        if (r_pv == '0) w_state_nxt = CLR_SWEEP;
      end
      CLR_SWEEP: begin
        w_sweep_nxt = r_sweep_addr + 1'b1;
        if (r_sweep_addr == c_SWEEP_LAST) w_state_nxt = CLR_IDLE;
      end
      default: w_state_nxt = CLR_IDLE;
    endcase
  end

  // The older op's byte has since moved into the write register or history
  always_comb begin
    case (r_psel[RD_LAT-1])
      HTU_FWD_S1: w_base = r_wr_data;
      HTU_FWD_S2: w_base = r_h1_data;
      HTU_FWD_S3: w_base = r_h2_data;
      default:    w_base = mem_rdata;
    endcase
    w_mod = w_base;
    case (r_pop[RD_LAT-1])
      HTU_OP_SET: w_mod[r_pb[RD_LAT-1]] = 1'b1;
      HTU_OP_CLR: w_mod[r_pb[RD_LAT-1]] = 1'b0;
      default:    w_mod = w_base;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive      <= 1'b0;
      r_state      <= CLR_IDLE;
      r_sweep_addr <= '0;
      r_pv         <= '0;
      r_pa         <= '0;
      r_pb         <= '0;
      r_pop        <= '0;
      r_psel       <= '0;
      r_wr_v       <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_h1_data    <= '0;
      r_h2_data    <= '0;
      r_upd_cnt    <= '0;
    end else begin
      r_alive      <= 1'b1;
      r_state      <= w_state_nxt;
      r_sweep_addr <= w_sweep_nxt;
      r_pv[0]      <= w_accept;
      r_pa[0]      <= w_byte;
      r_pb[0]      <= in_addr[2:0];
      r_pop[0]     <= in_op;
      r_psel[0]    <= w_fwd_sel;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pa[i]   <= r_pa[i-1];
        r_pb[i]   <= r_pb[i-1];
        r_pop[i]  <= r_pop[i-1];
        r_psel[i] <= r_psel[i-1];
      end
      r_wr_v <= r_pv[RD_LAT-1];
      if (r_pv[RD_LAT-1]) begin
        r_wr_addr <= r_pa[RD_LAT-1];
        r_wr_data <= w_mod;
      end
      r_h1_data <= r_wr_data;
      r_h2_data <= r_h1_data;
      if (r_wr_v) r_upd_cnt <= r_upd_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hashtable_updater.sv
`default_nettype none
// ============================================================================
// Module   : tb_hashtable_updater
// Purpose  : Self-checking bench for hashtable_updater (NBITS=6) against a
//            bitmap/acceptance model; honours HTU_FWD_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hashtable_updater;

  localparam int NB = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] in_addr = '0;
  logic          in_op = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          clr_all_req = 1'b0;
  logic          clr_all_busy;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rdata;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [7:0]    mem_wdata;
  logic [31:0]   upd_cnt;

  hashtable_updater #(
    .NBITS     (NB),
    .BM_AWIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_addr      (in_addr),
    .in_op        (in_op),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .clr_all_req  (clr_all_req),
    .clr_all_busy (clr_all_busy),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rdata    (mem_rdata),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wdata    (mem_wdata),
    .upd_cnt      (upd_cnt)
  );

  always #5 clk = ~clk;

  // Bitmap RAM: two-cycle read, read-old-data on a same-cycle collision
  logic [7:0]    ram [0:7] = '{default: 8'h00};
  logic [7:0]    ram_p1 = 8'h00;
  logic [7:0]    ram_p2 = 8'h00;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [7:0]    pre_data = 8'h00;

  always @(posedge clk) begin
    if (mem_rd_en) ram_p1 <= ram[mem_rd_addr];
    ram_p2 <= ram_p1;
    if (mem_wr_en) ram[mem_wr_addr] <= mem_wdata;
    else if (pre_we) ram[pre_addr] <= pre_data;
  end
  assign mem_rdata = ram_p2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t wlog[$];
  always @(negedge clk) if (mem_wr_en) wlog.push_back('{c: cyc, a: mem_wr_addr, d: mem_wdata});

  logic [7:0] model [0:7];
  int         last_acc [0:7];
  int         exp_cnt = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reset_model_hist();
    for (int i = 0; i < 8; i++) last_acc[i] = -100;
    exp_cnt = 0;
  endtask

  // Presents one request, checks the handshake delay, updates the model on acceptance
  task automatic do_req(input logic [5:0] key, input logic op, output int waits);
    int p;
    int e;
    in_addr  = key;
    in_op    = op;
    in_valid = 1'b1;
    waits    = 0;
    @(negedge clk);
    p = cyc;
`ifdef HTU_FWD_EN
    e = 0;
`else
    e = last_acc[key[5:3]] + 4 - p;
    if (e < 0) e = 0;
`endif
    while (!in_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      chk("stall_wait", 32'(waits), 32'(e));
      model[key[5:3]][key[2:0]] = op;
      last_acc[key[5:3]] = cyc;
      exp_cnt++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    model[a] = d;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_byte%0d", tag, i), 32'(ram[i]), 32'(model[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int         w;
    int         idle_c;
    logic       ready_ok;
    logic       found;
    logic [5:0] key;
    logic [2:0] exp_a [0:9];
    logic [7:0] exp_d [0:9];

    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    reset_model_hist();

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(clr_all_busy), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_upd_cnt", upd_cnt, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_release", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Two sets in one byte
    do_req(6'h09, 1'b1, w);
    do_req(6'h0F, 1'b1, w);
    settle();
    chk("two_sets_byte1", 32'(ram[1]), 32'h82);
    chk("two_sets_cnt", upd_cnt, 32'd2);

    // Clear one bit of a preloaded byte
    preload(3'd5, 8'hFF);
    do_req(6'h2C, 1'b0, w);
    settle();
    chk("clear_bit_byte5", 32'(ram[5]), 32'hEF);
    chk("clear_bit_cnt", upd_cnt, 32'(exp_cnt));

    // Clear-all with two updates in flight; the second arrives with the clear pulse
    wlog.delete();
    do_req(6'h01, 1'b1, w);
    clr_all_req = 1'b1;
    do_req(6'h3B, 1'b1, w);
    clr_all_req = 1'b0;
    chk("clr_same_cycle_wait", 32'(w), 32'd0);
    exp_a[0] = 3'd0; exp_d[0] = model[0];
    exp_a[1] = 3'd7; exp_d[1] = model[7];
    for (int i = 0; i < 8; i++) begin
      exp_a[i+2] = 3'(i);
      exp_d[i+2] = 8'h00;
    end
    ready_ok = 1'b1;
    idle_c   = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) chk("busy_after_req", 32'(clr_all_busy), 32'd1);
      if (clr_all_busy && in_ready) ready_ok = 1'b0;
      if (!clr_all_busy) begin
        idle_c = cyc;
        break;
      end
      @(posedge clk);
      #1 clr_all_req = (c == 5);
    end
    clr_all_req = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    chk("clr_ready_low", 32'(ready_ok), 32'd1);
    chk("clr_write_count", 32'(wlog.size()), 32'd10);
    for (int i = 0; i < wlog.size() && i < 10; i++) begin
      chk($sformatf("clr_wr%0d_addr", i), 32'(wlog[i].a), 32'(exp_a[i]));
      chk($sformatf("clr_wr%0d_data", i), 32'(wlog[i].d), 32'(exp_d[i]));
      if (i > 2) chk($sformatf("clr_wr%0d_cycle", i), 32'(wlog[i].c - wlog[i-1].c), 32'd1);
    end
    if (wlog.size() > 0) chk("busy_drop_after_last", 32'(idle_c), 32'(wlog[wlog.size()-1].c + 1));
    compare_all("after_clear");
    chk("clr_upd_cnt", upd_cnt, 32'(exp_cnt));

    // Back-to-back same-byte sets
    wlog.delete();
    do_req(6'h09, 1'b1, w);
    do_req(6'h0A, 1'b1, w);
`ifdef HTU_FWD_EN
    chk("b2b_stall_cycles", 32'(w), 32'd0);
`else
    chk("b2b_stall_cycles", 32'(w), 32'd3);
`endif
    settle();
    chk("b2b_byte1", 32'(ram[1]), 32'h06);
    chk("b2b_write_count", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
`ifdef HTU_FWD_EN
      chk("b2b_write_gap", 32'(wlog[1].c - wlog[0].c), 32'd1);
`else
      chk("b2b_write_gap", 32'(wlog[1].c - wlog[0].c), 32'd4);
`endif
    end

    // Randomized traffic biased toward a few bytes to provoke hazards
    for (int n = 0; n < 200; n++) begin
      key[5:3] = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'($urandom_range(0, 7));
      key[2:0] = 3'($urandom_range(0, 7));
      do_req(key, 1'($urandom_range(0, 1)), w);
      w = $urandom_range(0, 3);
      if (w >= 2) begin
        repeat (w - 1) @(posedge clk);
        #1;
      end
    end
    settle();
    compare_all("random");
    chk("random_upd_cnt", upd_cnt, 32'(exp_cnt));

    // Reset in the middle of a sweep
    for (int i = 0; i < 8; i++) preload(3'(i), 8'hFF);
    clr_all_req = 1'b1;
    @(posedge clk);
    #1 clr_all_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (mem_wr_en && mem_wr_addr == 3'd3) found = 1'b1;
    end
    chk("sweep_reached_addr3", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    wlog.delete();
    chk("midrst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("midrst_busy", 32'(clr_all_busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_upd_cnt", upd_cnt, 32'd0);
    for (int i = 0; i < 3; i++) model[i] = 8'h00;
    reset_model_hist();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready_release", 32'(in_ready), 32'd1);
    chk("midrst_idle", 32'(clr_all_busy), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_writes", 32'(wlog.size()), 32'd0);
    compare_all("midrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hashtable_updater.md
HASHTABLE_UPDATER -- requirements
Module: hashtable_updater

Interface
REQ-001 SHALL have parameter NBITS, default 15, the hash key width in bits.
REQ-002 SHALL have parameter BM_AWIDTH, default NBITS-3, the bitmap byte-address width.
REQ-003 SHALL have parameter RD_LAT, fixed at 2, the bitmap RAM read latency in cycles.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- in_addr  in  NBITS  key whose bitmap bit is updated
- in_op  in  1  1 = set bit, 0 = clear bit
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid and in_ready are both high
- clr_all_req  in  1  single-cycle pulse: zero the entire bitmap
- clr_all_busy  out  1  sweep pending or in progress
- mem_rd_en  out  1  RAM read strobe
- mem_rd_addr  out  BM_AWIDTH  RAM read byte address
- mem_rdata  in  8  RAM read data, RD_LAT cycles after mem_rd_en
- mem_wr_en  out  1  RAM write strobe
- mem_wr_addr  out  BM_AWIDTH  RAM write byte address
- mem_wdata  out  8  RAM write data
- upd_cnt  out  32  count of completed updates, wraps at 2^32

Function
REQ-005 SHALL split each key into byte address in_addr[NBITS-1:3] and bit index in_addr[2:0]; bit index b maps to data bit b (LSB = 0), matching the lookup side's (q >> bit) & 1 test.
REQ-006 SHALL do a read-modify-write for each accepted request at cycle T: mem_rd_en at T, modified byte computed at T+2, mem_wr_en/mem_wdata at T+3.
REQ-007 SHALL change only the addressed bit in the written byte; the other 7 bits keep their read (or forwarded) values.
REQ-008 SHALL accept one request per cycle when there is no hazard and no clear is active.
REQ-009 SHALL treat the RAM as read-old-data on a same-address read/write collision; a request is hazardous if its byte address matches any in-flight op at T+1..T+3.
REQ-010 SHALL update upd_cnt by one on each mem_wr_en cycle caused by a request; sweep writes are not counted.
REQ-011 SHALL run a clear FSM with states IDLE, DRAIN and SWEEP:
- IDLE -> DRAIN on clr_all_req
- DRAIN -> SWEEP once the pipeline is empty
- SWEEP writes 0x00 to byte addresses 0 .. 2^BM_AWIDTH-1, one per cycle, then -> IDLE
REQ-012 SHALL hold in_ready low in DRAIN and SWEEP, and hold clr_all_busy high from the cycle after clr_all_req until the last sweep write.
REQ-013 SHALL ignore clr_all_req while clr_all_busy is high.
REQ-014 SHALL give priority to clr_all_req when it arrives together with an accepted request; that request completes during DRAIN, before the sweep.
REQ-015 SHALL wrap the sweep address counter to 0 on return to IDLE.

Reset
REQ-016 SHALL on rst_n low, asynchronously:
- drive in_ready=0, clr_all_busy=0, mem_rd_en=0, mem_wr_en=0, addresses/data=0 and upd_cnt=0
- set the FSM to IDLE and clear all pipeline valids
REQ-017 SHALL raise in_ready the first cycle after reset release.
REQ-018 SHALL abandon any in-flight write or sweep on reset, with no partial write issued after reset assertion.

Configuration
REQ-019 SHALL, with macro HTU_FWD_EN defined, forward the youngest in-flight modified byte for a same-address op instead of stalling, so hazardous requests still issue one per cycle.
REQ-020 SHALL, without HTU_FWD_EN, deassert in_ready while the presented in_addr has a hazard per REQ-009, holding it low until the conflicting op has written.

Structure
REQ-021 SHALL place the op encoding (HTU_OP_CLR=0, HTU_OP_SET=1), the clear FSM state enum and the RD_LAT constant in package hashtable_pkg.
REQ-022 SHALL use one sub-module, htu_hazard, which compares the incoming byte address with the in-flight stages and returns the stall flag or the forward select.

Verification (NBITS=6, BM_AWIDTH=3, RAM model pre-zeroed)
REQ-023 SHALL check: set keys 0x09 then 0x0F in consecutive cycles -> byte 1 ends at 0x82, upd_cnt=2.
REQ-024 SHALL check, without HTU_FWD_EN: set 0x09 then set 0x0A back-to-back -> in_ready low for 3 cycles, then byte 1 = 0x06.
REQ-025 SHALL check, with HTU_FWD_EN: the same sequence -> no stall, byte 1 = 0x06, writes in consecutive cycles.
REQ-026 SHALL check: preload byte 5 = 0xFF, clear key 0x2C -> byte 5 = 0xEF.
REQ-027 SHALL check: clr_all_req while 2 updates are in flight -> both updates are written, then 8 zero writes to addresses 0..7, clr_all_busy deasserts after address 7, upd_cnt +2 only.
REQ-028 SHALL check: rst_n low mid-sweep at address 3 -> no further mem_wr_en, FSM IDLE, in_ready=1 one cycle after release.
